// File: rtl/led_counter_sequencer_if.sv
// Button and LED-side signals of the LED counter sequencer.
// The sequencer attaches through the slave modport.
interface led_counter_sequencer_if #(
    parameter int COUNT_W = 6
);
    logic               btn1;
    logic               btn2;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] led;
    logic               running;
    logic               tick;

    modport master (output btn1, btn2, input count, led, running, tick);
    modport slave  (input btn1, btn2, output count, led, running, tick);
endinterface

// File: rtl/led_counter_sequencer.sv
// Debounces two active-low buttons and drives a free-running / single-step LED counter.
//   state    | meaning
//   ST_RUN   | prescaler advances, count increments on every prescaler wrap
//   ST_PAUSE | prescaler held, btn2 press single-steps the count
module led_counter_sequencer #(
    parameter int TICK_PERIOD       = 13500000,
    parameter int DEBOUNCE_CYCLES   = 270000,
    parameter int LONG_PRESS_CYCLES = 27000000,
    parameter int COUNT_W           = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    led_counter_sequencer_if.slave bus
);
    localparam int PRESC_W = $clog2(TICK_PERIOD);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int LP_W    = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_PERIOD - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0]    LP_LAST    = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LP_W-1:0]    LP_FULL    = LP_W'(LONG_PRESS_CYCLES);

    typedef enum logic {ST_RUN, ST_PAUSE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         raw;
    logic [1:0]         sync_a;
    logic [1:0]         sync_b;
    logic [1:0]         deb;
    logic [1:0]         press;
    logic [DEB_W-1:0]   deb_cnt [2];
    logic [LP_W-1:0]    lp_cnt;
    logic               clear_done;
    logic               clear;
    logic [PRESC_W-1:0] presc;
    logic [COUNT_W-1:0] count;
    logic               tick;
    logic               run_mode;
    logic               step;
    logic               wrap;

    // Index 0 is btn1 (run/pause), index 1 is btn2 (step/clear).
    assign raw = {bus.btn2, bus.btn1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '1;
            sync_b <= '1;
            deb    <= '1;
            press  <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= sync_b[i];
                    press[i]   <= ~sync_b[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (press[0]) state_nxt = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end

    always_comb begin
        run_mode = 1'b0;
        step     = 1'b0;
        if (state == ST_RUN) run_mode = 1'b1;
        else                 step     = press[1];
    end

    assign wrap  = run_mode && (presc == PRESC_LAST);
    // Fires on the edge where the hold counter reaches LONG_PRESS_CYCLES; once per hold.
    assign clear = ~deb[1] & ~clear_done & (lp_cnt == LP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_cnt     <= '0;
            clear_done <= 1'b0;
        end else if (deb[1]) begin
            lp_cnt     <= '0;
            clear_done <= 1'b0;
        end else begin
            if (lp_cnt != LP_FULL) lp_cnt <= lp_cnt + 1'b1;
            if (clear)             clear_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                presc <= '0;
                count <= '0;
            end else begin
                if (run_mode) presc <= wrap ? '0 : presc + 1'b1;
                if (wrap || step) begin
                    count <= count + 1'b1;
                    tick  <= 1'b1;
                end
            end
        end
    end

    assign bus.count   = count;
    assign bus.led     = ~count;
    assign bus.running = run_mode;
    assign bus.tick    = tick;
endmodule

// File: tb/tb_led_counter_sequencer.sv
// Directed bench: each phase queues the count values its ticks must carry; a tick monitor pops and compares.
// Point checks sample on the falling edge at cycle offsets derived from the 2+DEBOUNCE latency.
module tb_led_counter_sequencer;
    localparam int TICK_PERIOD       = 5;
    localparam int DEBOUNCE_CYCLES   = 4;
    localparam int LONG_PRESS_CYCLES = 20;
    localparam int COUNT_W           = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   sb_exp;
    logic mon_en = 1'b0;

    led_counter_sequencer_if #(.COUNT_W(COUNT_W)) bus_if ();

    led_counter_sequencer #(
        .TICK_PERIOD       (TICK_PERIOD),
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .COUNT_W           (COUNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) exp_q.push_back(v);
    endtask

    task automatic wait_running(input logic want, input string tag);
        int n;
        n = 0;
        while (bus_if.running !== want && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(bus_if.running), 32'(want));
    endtask

    // Tick monitor: every tick cycle consumes one expected count value.
    always @(negedge clk) begin
        if (mon_en && !rst && bus_if.tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("tick_unexpected", 32'(bus_if.count), 32'hFFFF_FFFF);
            end else begin
                sb_exp = exp_q.pop_front();
                check_val("tick_count", 32'(bus_if.count), 32'(sb_exp));
            end
        end
    end

    initial begin
        rst         = 1'b0;
        bus_if.btn1 = 1'b1;
        bus_if.btn2 = 1'b1;
        #1 rst = 1'b1;
        wait_n(3);
        check_val("rst_count", 32'(bus_if.count), 0);
        check_val("rst_led", 32'(bus_if.led), 32'h3F);
        check_val("rst_running", 32'(bus_if.running), 1);
        check_val("rst_tick", 32'(bus_if.tick), 0);

        // Free run: ticks at cycles 5,10,...,40
        rst    = 1'b0;
        mon_en = 1'b1;
        push_range(1, 8);
        wait_n(40);
        check_val("free_count", 32'(bus_if.count), 8);
        check_val("free_led", 32'(bus_if.led), 32'h37);
        check_val("free_running", 32'(bus_if.running), 1);

        // Bounce on btn1, then a steady press -> exactly one toggle to PAUSE
        push_range(9, 12);
        wait_n(2);
        for (int i = 0; i < 6; i++) begin
            bus_if.btn1 = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_n(2);
        end
        bus_if.btn1 = 1'b0;
        wait_running(1'b0, "bounce_pause");
        check_val("bounce_count", 32'(bus_if.count), 12);
        bus_if.btn1 = 1'b1;
        wait_n(10);
        check_val("release_no_event", 32'(bus_if.running), 0);
        check_val("pause_hold_count", 32'(bus_if.count), 12);

        // Three single steps while paused
        push_range(13, 15);
        for (int i = 0; i < 3; i++) begin
            bus_if.btn2 = 1'b0;
            wait_n(8);
            bus_if.btn2 = 1'b1;
            wait_n(8);
        end
        check_val("step_count", 32'(bus_if.count), 15);
        check_val("step_led", 32'(bus_if.led), 32'h30);
        check_val("step_running", 32'(bus_if.running), 0);

        // Resume: prescaler was frozen at 1, so the next tick lands 4 cycles after RUN
        push_range(16, 16);
        bus_if.btn1 = 1'b0;
        wait_running(1'b1, "resume_run");
        bus_if.btn1 = 1'b1;
        wait_n(3);
        check_val("resume_pre_tick", 32'(bus_if.tick), 0);
        check_val("resume_pre_count", 32'(bus_if.count), 15);
        wait_n(1);
        check_val("resume_tick", 32'(bus_if.tick), 1);
        check_val("resume_count", 32'(bus_if.count), 16);

        // Long press in RUN; the clear lands on a prescaler wrap edge and must win
        push_range(17, 21);
        push_range(1, 6);
        wait_n(4);
        bus_if.btn2 = 1'b0;
        wait_n(25);
        check_val("lp_pre_clear", 32'(bus_if.count), 21);
        wait_n(1);
        check_val("lp_clear_count", 32'(bus_if.count), 0);
        check_val("lp_clear_tick", 32'(bus_if.tick), 0);
        check_val("lp_clear_running", 32'(bus_if.running), 1);
        wait_n(34);
        check_val("lp_single_clear", 32'(bus_if.count), 6);
        bus_if.btn2 = 1'b1;

        // Count wrap 63 -> 0
        push_range(7, 63);
        push_range(0, 0);
        wait_n(285);
        check_val("wrap_pre_count", 32'(bus_if.count), 63);
        check_val("wrap_pre_led", 32'(bus_if.led), 0);
        wait_n(1);
        check_val("wrap_count", 32'(bus_if.count), 0);
        check_val("wrap_tick", 32'(bus_if.tick), 1);

        // Reset while btn2 is held and count=17
        push_range(1, 17);
        wait_n(75);
        bus_if.btn2 = 1'b0;
        wait_n(11);
        check_val("mid_count", 32'(bus_if.count), 17);
        rst = 1'b1;
        #1;
        check_val("midrst_count", 32'(bus_if.count), 0);
        check_val("midrst_running", 32'(bus_if.running), 1);
        check_val("midrst_led", 32'(bus_if.led), 32'h3F);
        check_val("midrst_queue", 32'(exp_q.size()), 0);
        push_range(1, 5);
        wait_n(2);
        rst = 1'b0;
        // Held btn2 re-debounces (6 cycles) then needs 20 more cycles before clearing
        wait_n(25);
        check_val("redeb_pre_clear", 32'(bus_if.count), 5);
        wait_n(1);
        check_val("redeb_clear", 32'(bus_if.count), 0);
        check_val("redeb_tick", 32'(bus_if.tick), 0);
        mon_en      = 1'b0;
        bus_if.btn2 = 1'b1;
        check_val("sb_drain", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
